// File: rtl/grid_wb_buffered_pkg.sv
// Shared types and default sizing for the grid writeback stage.
// The result record is what the FIFO stores and what writeback sees at its head.
package rca_config;

    localparam int XLEN_DEFAULT            = 32;
    localparam int NUM_IO_UNITS_DEFAULT    = 8;
    localparam int NUM_WRITE_PORTS_DEFAULT = 2;
    localparam int RESULT_DEPTH_DEFAULT    = 4;

    // data[p] is the value written by register write port p; unused ports carry 0
    typedef struct packed {
        logic [NUM_WRITE_PORTS_DEFAULT-1:0][XLEN_DEFAULT-1:0] data;
        logic [NUM_WRITE_PORTS_DEFAULT-1:0]                   port_en;
    } grid_wb_result_t;

    typedef enum logic [1:0] {
        GWB_IDLE,
        GWB_CAPTURE,
        GWB_HOLD
    } grid_wb_state_t;

endpackage

// File: rtl/grid_wb_buffered_result_fifo.sv
// Synchronous FIFO of completed result sets. Head reads 0 while empty so
// writeback never sees stale data; flush empties it in one cycle.
module grid_wb_result_fifo
    import rca_config::*;
#(
    parameter int DEPTH = RESULT_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  grid_wb_result_t              push_data,
    input  logic                         pop,
    output grid_wb_result_t              head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    grid_wb_result_t   mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              pop_eff, push_eff;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop_eff  = pop && !empty;
    // a pop frees the slot in the same cycle, so a full FIFO still takes a push
    assign push_eff = push && (!full || pop_eff);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_eff) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_eff)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
        end
    end

    assign head  = empty ? '0 : mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/grid_wb_buffered.sv
// Writeback stage: collects one result per register write port from the selected
// grid I/O units, then queues the completed set for a valid/ack writeback consumer.
module grid_wb_buffered
    import rca_config::*;
#(
    parameter int XLEN            = XLEN_DEFAULT,
    parameter int NUM_IO_UNITS    = NUM_IO_UNITS_DEFAULT,
    parameter int NUM_WRITE_PORTS = NUM_WRITE_PORTS_DEFAULT,
    parameter int RESULT_DEPTH    = RESULT_DEPTH_DEFAULT
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [NUM_IO_UNITS-1:0][XLEN-1:0]                     io_unit_output_data,
    input  logic [NUM_IO_UNITS-1:0]                               io_unit_output_data_valid,
    input  logic [NUM_WRITE_PORTS-1:0][$clog2(NUM_IO_UNITS)-1:0]  io_unit_sels,
    input  logic [NUM_WRITE_PORTS-1:0]                            io_unit_port_en,
    input  logic                                                  io_unit_sels_valid,
    output logic                                                  sels_ready,
    input  logic                                                  flush,
    output logic                                                  wb_valid,
    output logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]                  wb_data,
    output logic [NUM_WRITE_PORTS-1:0]                            wb_port_en,
    input  logic                                                  wb_ack,
    output logic                                                  wb_committing,
    output logic [$clog2(RESULT_DEPTH+1)-1:0]                     result_count
);

    localparam int SEL_W = $clog2(NUM_IO_UNITS);

    grid_wb_state_t                        state_q, state_d;
    logic [NUM_WRITE_PORTS-1:0][SEL_W-1:0] sel_q, cur_sel;
    logic [NUM_WRITE_PORTS-1:0]            en_q, cur_en;
    logic [NUM_WRITE_PORTS-1:0]            cap_q, cur_cap, cap_next, hit;
    logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]  data_q, data_next;
    logic                                  in_idle, accept, active, complete;
    logic                                  pop, can_push, push;
    logic                                  fifo_full, fifo_empty;
    grid_wb_result_t                       fresh, held, push_data, head;

    assign in_idle    = (state_q == GWB_IDLE);
    assign sels_ready = in_idle && !flush;
    assign accept     = io_unit_sels_valid && sels_ready;
    assign active     = accept || (state_q == GWB_CAPTURE);

    // the accept cycle captures against the live selection, later cycles against the latched one
    assign cur_sel = in_idle ? io_unit_sels    : sel_q;
    assign cur_en  = in_idle ? io_unit_port_en : en_q;
    assign cur_cap = in_idle ? '0              : cap_q;

    for (genvar p = 0; p < NUM_WRITE_PORTS; p++) begin : g_port
        assign hit[p]       = active && cur_en[p] && !cur_cap[p]
                              && io_unit_output_data_valid[cur_sel[p]];
        assign cap_next[p]  = cur_cap[p] | hit[p];
        assign data_next[p] = hit[p]  ? io_unit_output_data[cur_sel[p]] :
                              in_idle ? '0 : data_q[p];
    end

    assign complete = active && ((cap_next & cur_en) == cur_en);
    assign pop      = wb_valid && wb_ack;
    assign can_push = !fifo_full || pop;

    assign fresh = '{data: data_next, port_en: cur_en};
    assign held  = '{data: data_q,    port_en: en_q};

    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= GWB_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_data = fresh;
        case (state_q)
            GWB_IDLE, GWB_CAPTURE: begin
                if (active) begin
                    if (!complete)
                        state_d = GWB_CAPTURE;
                    else if (can_push) begin
                        push    = 1'b1;
                        state_d = GWB_IDLE;
                    end else
                        state_d = GWB_HOLD;
                end
            end
            GWB_HOLD: begin
                push_data = held;
                if (can_push) begin
                    push    = 1'b1;
                    state_d = GWB_IDLE;
                end
            end
            default: state_d = GWB_IDLE;
        endcase
        if (flush) begin
            state_d = GWB_IDLE;
            push    = 1'b0;
        end
    end

    // capture registers also serve as the parked set while in HOLD
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            sel_q  <= '0;
            en_q   <= '0;
            cap_q  <= '0;
            data_q <= '0;
        end else begin
            if (accept) begin
                sel_q <= io_unit_sels;
                en_q  <= io_unit_port_en;
            end
            if (active) begin
                cap_q  <= cap_next;
                data_q <= data_next;
            end
        end
    end

    grid_wb_result_fifo #(
        .DEPTH(RESULT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (result_count)
    );

    assign wb_valid      = !fifo_empty;
    assign wb_data       = head.data;
    assign wb_port_en    = head.port_en;
    assign wb_committing = pop;

endmodule
